// File: rtl/decode_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_scan_if
// Purpose  : Bundles the control inputs and decoded outputs of decode_scan.
//            The master side drives enable/mode/select/load/dwell and
//            observes the decoded bus, index and advance pulse.
// Signals  : en     - enable; low forces outputs inactive
//            mode   - 0 direct decode, 1 auto-scan
//            a      - select value / scan load value (N bits)
//            load   - loads a into the scan index while scanning
//            dwell  - extra cycles each index is held while scanning (DW bits)
//            y      - registered decoded output (2**N bits)
//            idx    - index currently presented on y (N bits)
//            tick   - one-cycle pulse on each scan advance
// Revision : 1.0 - initial release
// ============================================================================
interface decode_scan_if #(
    parameter int N  = 3,
    parameter int DW = 16
) ();
    logic              en;
    logic              mode;
    logic [N-1:0]      a;
    logic              load;
    logic [DW-1:0]     dwell;
    logic [2**N-1:0]   y;
    logic [N-1:0]      idx;
    logic              tick;

    modport master (
        output en, mode, a, load, dwell,
        input  y, idx, tick
    );

    modport slave (
        input  en, mode, a, load, dwell,
        output y, idx, tick
    );
endinterface
`default_nettype wire

// File: rtl/decode_scan.sv
`default_nettype none
// ============================================================================
// Module   : decode_scan
// Purpose  : N-to-2**N decoder with a registered output and an auto-scan
//            mode that steps the selected line through all indices, holding
//            each one for dwell+1 cycles.
// Ports    : clk   - clock, all state updates on the rising edge
//            rst_n - synchronous active-low reset
//            bus   - decode_scan_if slave modport (en, mode, a, load, dwell
//                    in; y, idx, tick out)
// Params   : N   - select width
//            POL - 0: selected line high; 1: selected line low
//            DW  - dwell counter width
// Revision : 1.0 - initial release
// ============================================================================
module decode_scan #(
    parameter int N   = 3,
    parameter int POL = 0,
    parameter int DW  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    decode_scan_if.slave  bus
);

    localparam int              YW    = 2**N;
    localparam logic [YW-1:0]   Y_OFF = (POL != 0) ? {YW{1'b1}} : {YW{1'b0}};

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_DIRECT = 2'd1,
        S_SCAN   = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [YW-1:0]   y_reg, y_nx;
    logic [N-1:0]    idx_reg, idx_nx;
    logic [DW-1:0]   cnt, cnt_nx;
    logic            tick_reg, tick_nx;

    // One-hot decode with the output polarity folded in.
    function automatic logic [YW-1:0] decode(input logic [N-1:0] sel);
        logic [YW-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return (POL != 0) ? ~v : v;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_OFF;
            y_reg    <= Y_OFF;
            idx_reg  <= '0;
            cnt      <= '0;
            tick_reg <= 1'b0;
        end else begin
            state    <= state_nx;
            y_reg    <= y_nx;
            idx_reg  <= idx_nx;
            cnt      <= cnt_nx;
            tick_reg <= tick_nx;
        end
    end

    // The next state is chosen straight from en/mode, and the outputs
    // registered on this edge already reflect that next state, giving a
    // single cycle from input to output.
    always_comb begin
        state_nx = S_OFF;
        y_nx     = y_reg;
        idx_nx   = idx_reg;
        cnt_nx   = cnt;
        tick_nx  = 1'b0;

        if (!bus.en) begin
            state_nx = S_OFF;
        end else if (bus.mode) begin
            state_nx = S_SCAN;
        end else begin
            state_nx = S_DIRECT;
        end

        case (state_nx)
            S_OFF: begin
                // idx and count hold so a later scan resumes where it was
                y_nx = Y_OFF;
            end
            S_DIRECT: begin
                idx_nx = bus.a;
                cnt_nx = '0;
                y_nx   = decode(bus.a);
            end
            S_SCAN: begin
                if (bus.load) begin
                    idx_nx = bus.a;
                    cnt_nx = '0;
                end else if (state != S_SCAN) begin
                    // Entry: hold the current index for a full dwell+1 period
                    cnt_nx = '0;
                end else if (cnt >= bus.dwell) begin
                    // >= so a dwell lowered below the running count
                    // advances immediately instead of wrapping the counter
                    idx_nx  = idx_reg + 1'b1;
                    cnt_nx  = '0;
                    tick_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
                // y is derived from the same next index so the two agree
                y_nx = decode(idx_nx);
            end
            default: begin
                y_nx = Y_OFF;
            end
        endcase
    end

    assign bus.y    = y_reg;
    assign bus.idx  = idx_reg;
    assign bus.tick = tick_reg;

endmodule
`default_nettype wire

// File: tb/tb_decode_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_scan
// Purpose  : Self-checking bench for decode_scan. Two instances (POL=0 and
//            POL=1) receive identical stimulus; expected responses are queued
//            when stimulus is applied and checked by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_scan;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;
    int   vec;

    typedef struct {
        logic [7:0] y;
        logic [2:0] idx;
        logic       tick;
        int         due;
        int         tag;
    } exp_t;

    exp_t q[$];
    exp_t e;

    decode_scan_if #(.N(3), .DW(16)) bus0 ();
    decode_scan_if #(.N(3), .DW(16)) bus1 ();

    decode_scan #(.N(3), .POL(0), .DW(16)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    decode_scan #(.N(3), .POL(1), .DW(16)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int tag, input logic [7:0] got, input logic [7:0] want);
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("FAIL vec%0d %s got=%h want=%h", tag, nm, got, want);
        end
    endtask

    // Monitor: compares every expected entry due by the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            chk("y_pol0", e.tag, bus0.y, e.y);
            chk("y_pol1", e.tag, bus1.y, ~e.y);
            chk("idx",    e.tag, {5'd0, bus0.idx}, {5'd0, e.idx});
            chk("tick",   e.tag, {7'd0, bus0.tick}, {7'd0, e.tick});
        end
    end

    // Apply one cycle of stimulus and queue the response expected after
    // the coming rising edge.
    task automatic step(input logic r, input logic en, input logic mode,
                        input logic [2:0] a, input logic ld, input logic [15:0] dw,
                        input logic [7:0] ey, input logic [2:0] ei, input logic et);
        exp_t x;
        rst_n      = r;
        bus0.en    = en;   bus1.en    = en;
        bus0.mode  = mode; bus1.mode  = mode;
        bus0.a     = a;    bus1.a     = a;
        bus0.load  = ld;   bus1.load  = ld;
        bus0.dwell = dw;   bus1.dwell = dw;
        vec   = vec + 1;
        x.y   = ey;
        x.idx = ei;
        x.tick = et;
        x.due = cyc + 1;
        x.tag = vec;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc   = 0;
        total = 0;
        bad   = 0;
        vec   = 0;

        // reset
        step(0, 0, 0, 3'd0, 0, 16'd0, 8'h00, 3'd0, 0);
        step(0, 1, 1, 3'd5, 1, 16'd0, 8'h00, 3'd0, 0);

        // direct decode, POL=1 mirror, disable
        step(1, 1, 0, 3'd5, 0, 16'd0, 8'h20, 3'd5, 0);
        step(1, 1, 0, 3'd0, 0, 16'd0, 8'h01, 3'd0, 0);
        step(1, 1, 0, 3'd2, 0, 16'd0, 8'h04, 3'd2, 0);
        step(1, 0, 0, 3'd2, 0, 16'd0, 8'h00, 3'd2, 0);
        step(1, 1, 0, 3'd6, 0, 16'd0, 8'h40, 3'd6, 0);

        // scan dwell=2 from idx 6 with wrap
        step(1, 1, 1, 3'd0, 0, 16'd2, 8'h40, 3'd6, 0);
        step(1, 1, 1, 3'd0, 0, 16'd2, 8'h40, 3'd6, 0);
        step(1, 1, 1, 3'd0, 0, 16'd2, 8'h40, 3'd6, 0);
        step(1, 1, 1, 3'd0, 0, 16'd2, 8'h80, 3'd7, 1);
        step(1, 1, 1, 3'd0, 0, 16'd2, 8'h80, 3'd7, 0);
        step(1, 1, 1, 3'd0, 0, 16'd2, 8'h80, 3'd7, 0);
        step(1, 1, 1, 3'd0, 0, 16'd2, 8'h01, 3'd0, 1);
        step(1, 1, 1, 3'd0, 0, 16'd2, 8'h01, 3'd0, 0);

        // dwell=0: count (1) already past dwell, advance every cycle
        step(1, 1, 1, 3'd0, 0, 16'd0, 8'h02, 3'd1, 1);
        step(1, 1, 1, 3'd0, 0, 16'd0, 8'h04, 3'd2, 1);
        step(1, 1, 1, 3'd0, 0, 16'd0, 8'h08, 3'd3, 1);
        step(1, 1, 1, 3'd0, 0, 16'd0, 8'h10, 3'd4, 1);
        step(1, 1, 1, 3'd0, 0, 16'd0, 8'h20, 3'd5, 1);
        step(1, 1, 1, 3'd0, 0, 16'd0, 8'h40, 3'd6, 1);
        step(1, 1, 1, 3'd0, 0, 16'd0, 8'h80, 3'd7, 1);
        step(1, 1, 1, 3'd0, 0, 16'd0, 8'h01, 3'd0, 1);

        // dwell=3, load on the terminal-count cycle
        step(1, 1, 1, 3'd0, 0, 16'd3, 8'h01, 3'd0, 0);
        step(1, 1, 1, 3'd0, 0, 16'd3, 8'h01, 3'd0, 0);
        step(1, 1, 1, 3'd0, 0, 16'd3, 8'h01, 3'd0, 0);
        step(1, 1, 1, 3'd4, 1, 16'd3, 8'h10, 3'd4, 0);
        step(1, 1, 1, 3'd4, 0, 16'd3, 8'h10, 3'd4, 0);
        step(1, 1, 1, 3'd4, 0, 16'd3, 8'h10, 3'd4, 0);
        step(1, 1, 1, 3'd4, 0, 16'd3, 8'h10, 3'd4, 0);
        step(1, 1, 1, 3'd4, 0, 16'd3, 8'h20, 3'd5, 1);

        // reset mid-scan at idx 3, then restart scan from 0
        step(1, 1, 1, 3'd3, 1, 16'd3, 8'h08, 3'd3, 0);
        step(0, 1, 1, 3'd0, 0, 16'd3, 8'h00, 3'd0, 0);
        step(1, 1, 1, 3'd0, 0, 16'd3, 8'h01, 3'd0, 0);
        step(1, 1, 1, 3'd0, 0, 16'd3, 8'h01, 3'd0, 0);
        step(1, 1, 1, 3'd0, 0, 16'd3, 8'h01, 3'd0, 0);
        step(1, 1, 1, 3'd0, 0, 16'd3, 8'h01, 3'd0, 0);
        step(1, 1, 1, 3'd0, 0, 16'd3, 8'h02, 3'd1, 1);
        step(1, 1, 1, 3'd0, 0, 16'd3, 8'h02, 3'd1, 0);
        step(1, 1, 1, 3'd0, 0, 16'd3, 8'h02, 3'd1, 0);
        // dwell lowered below the running count (2): advance at once
        step(1, 1, 1, 3'd0, 0, 16'd1, 8'h04, 3'd2, 1);

        // load ignored in direct and off; resume scan from held idx with wrap
        step(1, 1, 0, 3'd7, 1, 16'd1, 8'h80, 3'd7, 0);
        step(1, 0, 0, 3'd1, 1, 16'd1, 8'h00, 3'd7, 0);
        step(1, 1, 1, 3'd1, 0, 16'd0, 8'h80, 3'd7, 0);
        step(1, 1, 1, 3'd1, 0, 16'd0, 8'h01, 3'd0, 1);
        step(1, 1, 1, 3'd1, 0, 16'd0, 8'h02, 3'd1, 1);

        repeat (3) @(posedge clk);
        #1;
        total = total + 1;
        if (q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain pending=%0d want=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
